mc_move_tracker: RTL and testbench

//  Downstream monitor/recorder for the missionary-cannibal solver. Each cycle it samples the solver's

---
 rtl/mc_pkg.sv | 36 +++
 rtl/mc_move_fifo.sv | 62 ++++++
 rtl/mc_move_tracker.sv | 141 ++++++++++++++
 tb/tb_mc_move_tracker.sv | 246 ++++++++++++++++++++++++
 4 files changed

// File: rtl/mc_pkg.sv
// Shared constants, record layout and safety helper for the missionary-cannibal
// move tracker.
package mc_pkg;

  localparam logic [2:0] MC_TOTAL = 3'd3;

  localparam logic [1:0] ERR_NONE   = 2'd0;
  localparam logic [1:0] ERR_UNSAFE = 2'd1;
  localparam logic [1:0] ERR_LOAD   = 2'd2;
  localparam logic [1:0] ERR_OVF    = 2'd3;

  // Move record layout: {dir, dm[1:0], dc[1:0]}
  localparam int MOVE_W       = 5;
  localparam int MOVE_DIR_BIT = 4;
  localparam int MOVE_DM_LSB  = 2;
  localparam int MOVE_DC_LSB  = 0;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_TRACK = 2'd1,
    ST_DONE  = 2'd2,
    ST_ERROR = 2'd3
  } mc_state_e;

  // Both banks must have no missionaries or at least as many as cannibals.
  function automatic logic state_safe(input logic [1:0] m, input logic [1:0] c);
    logic [2:0] am, ac, bm, bc;
    am = {1'b0, m};
    ac = {1'b0, c};
    if (am > MC_TOTAL || ac > MC_TOTAL) return 1'b0;
    bm = MC_TOTAL - am;
    bc = MC_TOTAL - ac;
    return ((am == 3'd0) || (am >= ac)) && ((bm == 3'd0) || (bm >= bc));
  endfunction

endpackage

// File: rtl/mc_move_fifo.sv
// First-word-fall-through move-record buffer; head entry is visible on data_o
// whenever the buffer is non-empty.
module mc_move_fifo #(
  parameter int WIDTH = 5,
  parameter int DEPTH = 8
) (
  input  logic             clock,
  input  logic             reset,
  input  logic             push_i,
  input  logic [WIDTH-1:0] data_i,
  input  logic             pop_i,
  output logic [WIDTH-1:0] data_o,
  output logic             full_o,
  output logic             empty_o
);

  localparam int AW = $clog2(DEPTH);
  localparam int CW = AW + 1;

  logic [WIDTH-1:0] mem_q [DEPTH];
  logic [AW-1:0]    wr_ptr_q, wr_ptr_d;
  logic [AW-1:0]    rd_ptr_q, rd_ptr_d;
  logic [CW-1:0]    count_q, count_d;
  logic             push_en, pop_en;

  assign empty_o = (count_q == '0);
  assign full_o  = (count_q == CW'(DEPTH));
  assign pop_en  = pop_i && !empty_o;
  // A push into a full buffer is accepted only when the head leaves on the same edge.
  assign push_en = push_i && (!full_o || pop_en);
  assign data_o  = empty_o ? '0 : mem_q[rd_ptr_q];

  // NOTE: combinational blocks assign every output a default first, so no path leaves a latch.
  always_comb begin
    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    count_d  = count_q;
    if (push_en) wr_ptr_d = wr_ptr_q + AW'(1);
    if (pop_en)  rd_ptr_d = rd_ptr_q + AW'(1);
    if (push_en && !pop_en)      count_d = count_q + CW'(1);
    else if (!push_en && pop_en) count_d = count_q - CW'(1);
  end

  // NOTE: sequential state uses non-blocking assignments so every flop samples pre-edge values.
  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
    end else begin
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      count_q  <= count_d;
    end
  end

  // NOTE: storage is not reset; occupancy gates data_o, so stale entries are never observed.
  always_ff @(posedge clock) begin
    if (push_en) mem_q[wr_ptr_q] <= data_i;
  end

endmodule

// File: rtl/mc_move_tracker.sv
// Monitors the solver's bank-A state, infers each boat move, checks legality and
// streams legal move records out through a small buffer.
module mc_move_tracker
  import mc_pkg::*;
#(
  parameter int FIFO_DEPTH = 8,
  parameter int STEP_W     = 6
) (
  input  logic              clock,
  input  logic              reset,
  input  logic [1:0]        missionary_in,
  input  logic [1:0]        cannibal_in,
  input  logic              finish_in,
  output logic              move_valid,
  input  logic              move_ready,
  output logic [MOVE_W-1:0] move_data,
  output logic [STEP_W-1:0] step_count,
  output logic              done,
  output logic              error,
  output logic [1:0]        error_code
);

  mc_state_e         state_q, state_d;
  logic [1:0]        prev_m_q, prev_m_d;
  logic [1:0]        prev_c_q, prev_c_d;
  logic [STEP_W-1:0] step_q, step_d;
  logic [1:0]        err_q, err_d;

  logic [2:0]        m_new, c_new, m_old, c_old;
  logic [2:0]        dm, dc, load;
  logic              m_up, m_down, c_up, c_down;
  logic              changed, sample_safe, load_ok;
  logic [MOVE_W-1:0] rec;
  logic              push, pop, fifo_full, fifo_empty;

  assign m_new   = {1'b0, missionary_in};
  assign c_new   = {1'b0, cannibal_in};
  assign m_old   = {1'b0, prev_m_q};
  assign c_old   = {1'b0, prev_c_q};
  assign m_up    = m_new > m_old;
  assign m_down  = m_new < m_old;
  assign c_up    = c_new > c_old;
  assign c_down  = c_new < c_old;
  assign changed = m_up || m_down || c_up || c_down;
  assign dm      = m_down ? (m_old - m_new) : (m_new - m_old);
  assign dc      = c_down ? (c_old - c_new) : (c_new - c_old);
  assign load    = dm + dc;

  // Boat carries one or two people, all travelling in the same direction.
  assign load_ok = (load >= 3'd1) && (load <= 3'd2) &&
                   !(m_up && c_down) && !(m_down && c_up);
  assign sample_safe = state_safe(missionary_in, cannibal_in);

  always_comb begin
    rec = '0;
    rec[MOVE_DIR_BIT]        = m_up || c_up;
    rec[MOVE_DM_LSB +: 2]    = dm[1:0];
    rec[MOVE_DC_LSB +: 2]    = dc[1:0];
  end

  assign move_valid = !fifo_empty;
  assign pop        = move_valid && move_ready;

  always_comb begin
    state_d  = state_q;
    prev_m_d = prev_m_q;
    prev_c_d = prev_c_q;
    step_d   = step_q;
    err_d    = err_q;
    push     = 1'b0;
    case (state_q)
      ST_IDLE: begin
        prev_m_d = missionary_in;
        prev_c_d = cannibal_in;
        if (!sample_safe) begin
          state_d = ST_ERROR;
          err_d   = ERR_UNSAFE;
        end else begin
          state_d = ST_TRACK;
        end
      end
      ST_TRACK: begin
        if (changed) begin
          if (!sample_safe) begin
            state_d = ST_ERROR;
            err_d   = ERR_UNSAFE;
          end else if (!load_ok) begin
            state_d = ST_ERROR;
            err_d   = ERR_LOAD;
          end else if (fifo_full && !pop) begin
            state_d = ST_ERROR;
            err_d   = ERR_OVF;
          end else begin
            push     = 1'b1;
            prev_m_d = missionary_in;
            prev_c_d = cannibal_in;
            step_d   = (&step_q) ? step_q : step_q + STEP_W'(1);
            if (finish_in) state_d = ST_DONE;
          end
        end
      end
      default: ;
    endcase
  end

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      state_q  <= ST_IDLE;
      prev_m_q <= '0;
      prev_c_q <= '0;
      step_q   <= '0;
      err_q    <= ERR_NONE;
    end else begin
      state_q  <= state_d;
      prev_m_q <= prev_m_d;
      prev_c_q <= prev_c_d;
      step_q   <= step_d;
      err_q    <= err_d;
    end
  end

  mc_move_fifo #(
    .WIDTH (MOVE_W),
    .DEPTH (FIFO_DEPTH)
  ) u_fifo (
    .clock   (clock),
    .reset   (reset),
    .push_i  (push),
    .data_i  (rec),
    .pop_i   (pop),
    .data_o  (move_data),
    .full_o  (fifo_full),
    .empty_o (fifo_empty)
  );

  assign step_count = step_q;
  assign done       = (state_q == ST_DONE);
  assign error      = (state_q == ST_ERROR);
  assign error_code = err_q;

endmodule

// File: tb/tb_mc_move_tracker.sv
// Scoreboard bench for mc_move_tracker: expected move records are queued when a
// legal move is driven and compared as the DUT hands them out.
module tb_mc_move_tracker;

  localparam int STEP_W = 6;

  logic              clock = 1'b0;
  logic              reset = 1'b1;
  logic [1:0]        missionary_in = '0;
  logic [1:0]        cannibal_in = '0;
  logic              finish_in = 1'b0;
  logic              move_valid;
  logic              move_ready = 1'b1;
  logic [4:0]        move_data;
  logic [STEP_W-1:0] step_count;
  logic              done;
  logic              error;
  logic [1:0]        error_code;

  int n_checks = 0;
  int n_fail   = 0;
  logic [4:0] sb[$];
  int pm, pc;

  int sol_m[11] = '{3, 3, 3, 3, 1, 2, 0, 0, 0, 0, 0};
  int sol_c[11] = '{1, 2, 0, 1, 1, 2, 2, 3, 1, 2, 0};

  mc_move_tracker #(
    .FIFO_DEPTH (4),
    .STEP_W     (STEP_W)
  ) dut (
    .clock         (clock),
    .reset         (reset),
    .missionary_in (missionary_in),
    .cannibal_in   (cannibal_in),
    .finish_in     (finish_in),
    .move_valid    (move_valid),
    .move_ready    (move_ready),
    .move_data     (move_data),
    .step_count    (step_count),
    .done          (done),
    .error         (error),
    .error_code    (error_code)
  );

  always #5 clock = ~clock;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    if (obs !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
    end
  endtask

  function automatic logic [4:0] exp_rec(input int om, input int oc, input int m, input int c);
    int   dmv = (m > om) ? m - om : om - m;
    int   dcv = (c > oc) ? c - oc : oc - c;
    logic dir = (m + c) > (om + oc);
    return {dir, 2'(dmv), 2'(dcv)};
  endfunction

  // Any record the DUT hands over must match the oldest expected one.
  always @(negedge clock) begin
    if (!reset && move_valid && move_ready) begin
      check("sb_has_entry", 32'(sb.size() != 0), 32'd1);
      if (sb.size() != 0) check("record", 32'(move_data), 32'(sb.pop_front()));
    end
  end

  task automatic reset_dut();
    reset         = 1'b1;
    missionary_in = '0;
    cannibal_in   = '0;
    finish_in     = 1'b0;
    sb.delete();
    repeat (2) @(posedge clock);
    @(negedge clock);
    reset = 1'b0;
    #1;
  endtask

  task automatic baseline(input int m, input int c);
    missionary_in = 2'(m);
    cannibal_in   = 2'(c);
    pm = m;
    pc = c;
    @(posedge clock);
    #1;
  endtask

  task automatic move(input int m, input int c, input logic fin, input bit legal);
    missionary_in = 2'(m);
    cannibal_in   = 2'(c);
    finish_in     = fin;
    if (legal) begin
      sb.push_back(exp_rec(pm, pc, m, c));
      pm = m;
      pc = c;
    end
    @(posedge clock);
    #1;
    finish_in = 1'b0;
  endtask

  task automatic drain(input string tag);
    for (int i = 0; i < 40 && sb.size() != 0; i++) begin
      @(posedge clock);
      #1;
    end
    check({tag, "_drained"}, 32'(sb.size()), 32'd0);
    check({tag, "_valid_low"}, 32'(move_valid), 32'd0);
  endtask

  task automatic check_status(input string tag, input int steps, input logic d,
                              input logic e, input int code);
    check({tag, "_steps"}, 32'(step_count), 32'(steps));
    check({tag, "_done"},  32'(done), 32'(d));
    check({tag, "_error"}, 32'(error), 32'(e));
    check({tag, "_code"},  32'(error_code), 32'(code));
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1);
  end

  initial begin
    // Reset values and a single legal move
    move_ready = 1'b1;
    reset_dut();
    check("rst_valid", 32'(move_valid), 32'd0);
    check("rst_data", 32'(move_data), 32'd0);
    check_status("rst", 0, 1'b0, 1'b0, 0);
    baseline(3, 3);
    move(2, 2, 1'b0, 1'b1);
    check("t1_valid", 32'(move_valid), 32'd1);
    check_status("t1", 1, 1'b0, 1'b0, 0);
    drain("t1");

    // Complete 11-move solution ending in finish
    reset_dut();
    baseline(3, 3);
    for (int i = 0; i < 11; i++) move(sol_m[i], sol_c[i], i == 10, 1'b1);
    check_status("t2", 11, 1'b1, 1'b0, 0);
    drain("t2");
    move(1, 1, 1'b0, 1'b0);
    check_status("t2_after", 11, 1'b1, 1'b0, 0);

    // Unsafe bank A, then later inputs ignored
    reset_dut();
    baseline(3, 3);
    move(1, 3, 1'b0, 1'b0);
    check_status("t3", 0, 1'b0, 1'b1, 1);
    move(2, 2, 1'b0, 1'b0);
    move(3, 3, 1'b0, 1'b0);
    check_status("t3_ignored", 0, 1'b0, 1'b1, 1);
    check("t3_valid", 32'(move_valid), 32'd0);

    // Unsafe and overloaded at once: unsafe wins
    reset_dut();
    baseline(3, 3);
    move(1, 2, 1'b0, 1'b0);
    check_status("t3b", 0, 1'b0, 1'b1, 1);

    // Unsafe baseline
    reset_dut();
    baseline(1, 2);
    check_status("t3c", 0, 1'b0, 1'b1, 1);

    // Boat load of three
    reset_dut();
    baseline(3, 3);
    move(3, 0, 1'b0, 1'b0);
    check_status("t4", 0, 1'b0, 1'b1, 2);
    check("t4_valid", 32'(move_valid), 32'd0);

    // Deltas moving in opposite directions
    reset_dut();
    baseline(3, 1);
    move(2, 2, 1'b0, 1'b0);
    check_status("t4b", 0, 1'b0, 1'b1, 2);

    // Error takes precedence over finish
    reset_dut();
    baseline(0, 3);
    move(0, 0, 1'b1, 1'b0);
    check_status("t4c", 0, 1'b0, 1'b1, 2);

    // Overflow of a 4-entry buffer, then ordered drain
    reset_dut();
    move_ready = 1'b0;
    baseline(3, 3);
    for (int i = 0; i < 4; i++) move(sol_m[i], sol_c[i], 1'b0, 1'b1);
    check("t5_full_valid", 32'(move_valid), 32'd1);
    check("t5_head_held", 32'(move_data), 32'(sb[0]));
    move(sol_m[4], sol_c[4], 1'b0, 1'b0);
    check_status("t5", 4, 1'b0, 1'b1, 3);
    check("t5_head_stable", 32'(move_data), 32'(sb[0]));
    move_ready = 1'b1;
    drain("t5");

    // Full buffer with simultaneous push and pop keeps going
    reset_dut();
    move_ready = 1'b0;
    baseline(3, 3);
    for (int i = 0; i < 4; i++) move(sol_m[i], sol_c[i], 1'b0, 1'b1);
    move_ready = 1'b1;
    for (int i = 4; i < 8; i++) move(sol_m[i], sol_c[i], 1'b0, 1'b1);
    check_status("t5b", 8, 1'b0, 1'b0, 0);
    drain("t5b");

    // Step counter saturates at all-ones
    reset_dut();
    baseline(3, 3);
    for (int i = 0; i < 70; i++) move((i % 2 == 0) ? 2 : 3, (i % 2 == 0) ? 2 : 3, 1'b0, 1'b1);
    check_status("t_sat", 63, 1'b0, 1'b0, 0);
    drain("t_sat");

    // Reset mid-operation with records queued, then fresh baseline
    reset_dut();
    move_ready = 1'b0;
    baseline(3, 3);
    for (int i = 0; i < 3; i++) move(sol_m[i], sol_c[i], 1'b0, 1'b1);
    check("t6_queued", 32'(move_valid), 32'd1);
    #2;
    reset = 1'b1;
    #1;
    check("t6_valid", 32'(move_valid), 32'd0);
    check("t6_data", 32'(move_data), 32'd0);
    check_status("t6", 0, 1'b0, 1'b0, 0);
    sb.delete();
    @(negedge clock);
    reset      = 1'b0;
    move_ready = 1'b1;
    baseline(3, 1);
    move(3, 2, 1'b0, 1'b1);
    check_status("t6_after", 1, 1'b0, 1'b0, 0);
    drain("t6");

    $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
    $finish;
  end

endmodule
